// File: rtl/tpu_ctrl_pkg.sv
// Shared definitions for the TPU control path: instruction width, field
// layout of the 5-bit control-unit instruction, the program entry record
// and the sequencer state encoding.
package tpu_ctrl_pkg;

  localparam int INSTR_W = 5;
  localparam int HOLD_W  = 8;

  // Activation select, instruction bits [1:0]
  localparam logic [1:0] ACT_NONE    = 2'b00;
  localparam logic [1:0] ACT_RELU    = 2'b01;
  localparam logic [1:0] ACT_SIGMOID = 2'b10;
  localparam logic [1:0] ACT_TANH    = 2'b11;

  // Single-bit control lines
  localparam int NN_START_BIT     = 2;
  localparam int LOAD_INPUTS_BIT  = 3;
  localparam int LOAD_WEIGHTS_BIT = 4;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [HOLD_W-1:0]  hold;
  } prog_entry_t;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } seq_state_t;

endpackage

// File: rtl/instruction_sequencer_if.sv
// Host/control-unit side bundle of the instruction sequencer.
//   master : host (program load, start/stall/abort) observing the outputs
//   slave  : the sequencer itself
interface instruction_sequencer_if #(
  parameter int DEPTH   = 16,
  parameter int INSTR_W = 5,
  parameter int HOLD_W  = 8,
  parameter int AW      = $clog2(DEPTH)
);
  logic               prog_wr_en;
  logic [AW-1:0]      prog_wr_addr;
  logic [INSTR_W-1:0] prog_wr_instr;
  logic [HOLD_W-1:0]  prog_wr_hold;
  logic               start;
  logic [AW:0]        prog_len;
  logic               stall;
  logic               abort;
  logic [INSTR_W-1:0] instruction;
  logic               instr_valid;
  logic [AW-1:0]      pc;
  logic               busy;
  logic               done;

  modport master (
    output prog_wr_en, prog_wr_addr, prog_wr_instr, prog_wr_hold,
    output start, prog_len, stall, abort,
    input  instruction, instr_valid, pc, busy, done
  );

  modport slave (
    input  prog_wr_en, prog_wr_addr, prog_wr_instr, prog_wr_hold,
    input  start, prog_len, stall, abort,
    output instruction, instr_valid, pc, busy, done
  );
endinterface

// File: rtl/seq_prog_mem.sv
// Program store: DEPTH x prog_entry_t register file, one synchronous write
// port and one combinational read port. A read of the address being written
// in the same cycle returns the incoming data, so a start issued together
// with a write to entry 0 plays the new entry.
//   clk     : clock
//   wr_en   : write strobe (already qualified by the caller)
//   wr_addr : write address
//   wr_data : entry to store
//   rd_addr : read address
//   rd_data : entry read (write-first)
module seq_prog_mem
  import tpu_ctrl_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        wr_en,
  input  logic [AW-1:0] wr_addr,
  input  prog_entry_t wr_data,
  input  logic [AW-1:0] rd_addr,
  output prog_entry_t rd_data
);

  prog_entry_t mem_r [DEPTH];

  // Write port; contents are intentionally not cleared by reset
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_r[wr_addr] <= wr_data;
    end
  end

  // Read port with write-first bypass
  always_comb begin
    rd_data = mem_r[rd_addr];
    if (wr_en && (wr_addr == rd_addr)) begin
      rd_data = wr_data;
    end else begin
      rd_data = mem_r[rd_addr];
    end
  end

endmodule

// File: rtl/instruction_sequencer.sv
// Programmable instruction player feeding the TPU control unit.
// The host loads {instruction, hold} entries, then pulses start; each entry
// is presented for hold+1 cycles, stall freezes playback, abort returns to
// idle without a done pulse, and done pulses once on normal completion.
//   clk, rst : clock, synchronous active-high reset
//   bus      : slave side of instruction_sequencer_if (program write port,
//              start/prog_len/stall/abort in; instruction, instr_valid, pc,
//              busy, done out - all outputs registered)
module instruction_sequencer #(
  parameter int DEPTH   = 16,
  parameter int INSTR_W = 5,
  parameter int HOLD_W  = 8,
  parameter int AW      = $clog2(DEPTH)
) (
  input logic clk,
  input logic rst,
  instruction_sequencer_if.slave bus
);
  import tpu_ctrl_pkg::*;

  localparam logic [AW:0] DEPTH_LEN = (AW+1)'(DEPTH);

  seq_state_t         state_r, state_s;
  logic [AW-1:0]      pc_r, pc_s;
  logic [HOLD_W-1:0]  hold_r, hold_s;
  logic [AW:0]        len_r, len_s;
  logic [INSTR_W-1:0] instr_r, instr_s;
  logic               valid_r, valid_s;
  logic               busy_r, busy_s;
  logic               done_r, done_s;

  logic               wr_en_s;
  logic [AW-1:0]      rd_addr_s;
  logic [AW:0]        start_len_s;
  logic               last_s;
  prog_entry_t        wr_entry_s;
  prog_entry_t        rd_entry_s;

  // Program writes are only taken while idle
  assign wr_en_s    = bus.prog_wr_en & ~busy_r;
  assign wr_entry_s = {bus.prog_wr_instr, bus.prog_wr_hold};

  // Lengths beyond the store size play the whole store
  assign start_len_s = (bus.prog_len > DEPTH_LEN) ? DEPTH_LEN : bus.prog_len;

  // Length is >= 1 whenever this is consulted (RUN only)
  assign last_s = ({1'b0, pc_r} == (len_r - (AW+1)'(1)));

  // Idle fetches entry 0 for a start; RUN prefetches the following entry
  always_comb begin
    if (state_r == RUN) begin
      rd_addr_s = pc_r + AW'(1);
    end else begin
      rd_addr_s = {AW{1'b0}};
    end
  end

  seq_prog_mem #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_prog_mem (
    .clk     (clk),
    .wr_en   (wr_en_s),
    .wr_addr (bus.prog_wr_addr),
    .wr_data (wr_entry_s),
    .rd_addr (rd_addr_s),
    .rd_data (rd_entry_s)
  );

  // Next-state and next-output logic; abort overrides stall and start
  always_comb begin
    state_s = state_r;
    pc_s    = pc_r;
    hold_s  = hold_r;
    len_s   = len_r;
    instr_s = instr_r;
    valid_s = valid_r;
    busy_s  = busy_r;
    done_s  = 1'b0;
    if (bus.abort) begin
      state_s = IDLE;
      pc_s    = {AW{1'b0}};
      hold_s  = {HOLD_W{1'b0}};
      instr_s = {INSTR_W{1'b0}};
      valid_s = 1'b0;
      busy_s  = 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          instr_s = {INSTR_W{1'b0}};
          valid_s = 1'b0;
          busy_s  = 1'b0;
          if (bus.start && (start_len_s != {(AW+1){1'b0}})) begin
            state_s = RUN;
            pc_s    = {AW{1'b0}};
            hold_s  = rd_entry_s.hold;
            len_s   = start_len_s;
            instr_s = rd_entry_s.instr;
            valid_s = 1'b1;
            busy_s  = 1'b1;
          end else if (bus.start) begin
            done_s = 1'b1;
          end else begin
            done_s = 1'b0;
          end
        end
        RUN: begin
          if (bus.stall) begin
            state_s = RUN;
          end else if (hold_r != {HOLD_W{1'b0}}) begin
            hold_s = hold_r - HOLD_W'(1);
          end else if (!last_s) begin
            pc_s    = pc_r + AW'(1);
            hold_s  = rd_entry_s.hold;
            instr_s = rd_entry_s.instr;
          end else begin
            state_s = IDLE;
            pc_s    = {AW{1'b0}};
            instr_s = {INSTR_W{1'b0}};
            valid_s = 1'b0;
            busy_s  = 1'b0;
            done_s  = 1'b1;
          end
        end
        default: begin
          state_s = IDLE;
          pc_s    = {AW{1'b0}};
          hold_s  = {HOLD_W{1'b0}};
          instr_s = {INSTR_W{1'b0}};
          valid_s = 1'b0;
          busy_s  = 1'b0;
        end
      endcase
    end
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
      pc_r    <= {AW{1'b0}};
      hold_r  <= {HOLD_W{1'b0}};
      len_r   <= {(AW+1){1'b0}};
      instr_r <= {INSTR_W{1'b0}};
      valid_r <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      pc_r    <= pc_s;
      hold_r  <= hold_s;
      len_r   <= len_s;
      instr_r <= instr_s;
      valid_r <= valid_s;
      busy_r  <= busy_s;
      done_r  <= done_s;
    end
  end

  assign bus.instruction = instr_r;
  assign bus.instr_valid = valid_r;
  assign bus.pc          = pc_r;
  assign bus.busy        = busy_r;
  assign bus.done        = done_r;

endmodule

// File: tb/tb_instruction_sequencer.sv
// Bench for instruction_sequencer: directed scenarios followed by random
// programs/stalls/aborts, all compared against a queue-based model that
// expands a program into its per-cycle instruction stream.
module tb_instruction_sequencer;
  import tpu_ctrl_pkg::*;

  localparam int DEPTH = 16;
  localparam int AW    = 4;

  typedef struct {
    logic [4:0] instr;
    int         pc;
  } item_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  instruction_sequencer_if #(.DEPTH(DEPTH)) bus ();

  instruction_sequencer #(.DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  // Reference model state
  logic [4:0] m_instr [DEPTH];
  int         m_hold  [DEPTH];
  item_t      m_q[$];
  item_t      m_cur;
  bit         m_valid;
  bit         m_done;

  int    n_checks;
  int    n_pass;
  string phase;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s/%s: got %0h expected %0h", phase, tag, got, exp);
    end
  endtask

  // One clock: drive inputs, advance the model, compare after the edge
  task automatic tick(input bit r, input bit we, input int addr, input int ins, input int hd,
                      input bit st, input int len, input bit sl, input bit ab);
    int n;
    rst               = r;
    bus.prog_wr_en    = we;
    bus.prog_wr_addr  = addr[AW-1:0];
    bus.prog_wr_instr = ins[4:0];
    bus.prog_wr_hold  = hd[7:0];
    bus.start         = st;
    bus.prog_len      = len[AW:0];
    bus.stall         = sl;
    bus.abort         = ab;
    if (r) begin
      m_valid = 1'b0;
      m_done  = 1'b0;
      m_q.delete();
    end else begin
      if (we && !m_valid) begin
        m_instr[addr] = ins[4:0];
        m_hold[addr]  = hd;
      end
      m_done = 1'b0;
      if (ab) begin
        m_valid = 1'b0;
        m_q.delete();
      end else if (m_valid) begin
        if (!sl) begin
          if (m_q.size() == 0) begin
            m_valid = 1'b0;
            m_done  = 1'b1;
          end else begin
            m_cur = m_q.pop_front();
          end
        end
      end else if (st) begin
        n = (len > DEPTH) ? DEPTH : len;
        if (n == 0) begin
          m_done = 1'b1;
        end else begin
          for (int k = 0; k < n; k++) begin
            for (int h = 0; h <= m_hold[k]; h++) begin
              m_q.push_back('{instr: m_instr[k], pc: k});
            end
          end
          m_cur   = m_q.pop_front();
          m_valid = 1'b1;
        end
      end
    end
    @(posedge clk);
    @(negedge clk);
    check_eq("valid", 32'(bus.instr_valid), 32'(m_valid));
    check_eq("instr", 32'(bus.instruction), m_valid ? 32'(m_cur.instr) : 32'd0);
    check_eq("busy",  32'(bus.busy), 32'(m_valid));
    check_eq("done",  32'(bus.done), 32'(m_done));
    if (m_valid) begin
      check_eq("pc", 32'(bus.pc), 32'(m_cur.pc));
    end
  endtask

  task automatic idle_tick();
    tick(1'b0, 1'b0, 0, 0, 0, 1'b0, 0, 1'b0, 1'b0);
  endtask

  task automatic load(input int addr, input int ins, input int hd);
    tick(1'b0, 1'b1, addr, ins, hd, 1'b0, 0, 1'b0, 1'b0);
  endtask

  task automatic go(input int len);
    tick(1'b0, 1'b0, 0, 0, 0, 1'b1, len, 1'b0, 1'b0);
  endtask

  task automatic drain();
    for (int i = 0; i < 400 && (bus.busy || m_valid || m_done); i++) begin
      idle_tick();
    end
    check_eq("drain_busy", 32'(bus.busy), 32'd0);
  endtask

  task automatic load_small();
    load(0, 5'b00100, 0);
    load(1, 5'b01000, 2);
    load(2, 5'b10011, 0);
  endtask

  int bcnt;
  int dcnt;

  initial begin
    n_checks = 0;
    n_pass   = 0;
    m_valid  = 1'b0;
    m_done   = 1'b0;

    phase = "reset";
    tick(1'b1, 1'b0, 0, 0, 0, 1'b0, 0, 1'b0, 1'b0);
    tick(1'b1, 1'b0, 0, 0, 0, 1'b0, 0, 1'b0, 1'b0);
    check_eq("pc", 32'(bus.pc), 32'd0);

    phase = "fill";
    for (int k = 0; k < DEPTH; k++) load(k, (k * 3) % 32, 0);

    phase = "len0";
    go(0);
    idle_tick();

    phase = "len17";
    go(DEPTH + 1);
    bcnt = bus.busy;
    for (int i = 0; i < DEPTH + 2; i++) begin
      idle_tick();
      bcnt += bus.busy;
    end
    check_eq("busy_cycles", 32'(bcnt), 32'(DEPTH));

    phase = "basic";
    load_small();
    go(3);
    bcnt = bus.busy;
    dcnt = bus.done;
    for (int i = 0; i < 7; i++) begin
      idle_tick();
      bcnt += bus.busy;
      dcnt += bus.done;
    end
    check_eq("busy_cycles", 32'(bcnt), 32'd5);
    check_eq("done_pulses", 32'(dcnt), 32'd1);

    phase = "stall";
    go(3);
    bcnt = bus.busy;
    idle_tick();
    bcnt += bus.busy;
    for (int i = 0; i < 4; i++) begin
      tick(1'b0, 1'b0, 0, 0, 0, 1'b0, 0, 1'b1, 1'b0);
      bcnt += bus.busy;
    end
    for (int i = 0; i < 6; i++) begin
      idle_tick();
      bcnt += bus.busy;
    end
    check_eq("busy_cycles", 32'(bcnt), 32'd9);

    phase = "abort";
    go(3);
    idle_tick();
    tick(1'b0, 1'b0, 0, 0, 0, 1'b1, 3, 1'b1, 1'b1);
    check_eq("pc_after_abort", 32'(bus.pc), 32'd0);
    dcnt = bus.done;
    for (int i = 0; i < 4; i++) begin
      idle_tick();
      dcnt += bus.done;
    end
    check_eq("no_done", 32'(dcnt), 32'd0);
    go(3);
    drain();

    phase = "run_ignore";
    go(3);
    tick(1'b0, 1'b1, 1, 5'b11111, 7, 1'b1, 1, 1'b0, 1'b0);
    drain();
    go(3);
    drain();

    phase = "wr_start";
    tick(1'b0, 1'b1, 0, 5'b11111, 1, 1'b1, 1, 1'b0, 1'b0);
    check_eq("first_instr", 32'(bus.instruction), 32'h1f);
    drain();

    phase = "rst_mid";
    load(0, 5'b00100, 0);
    go(3);
    idle_tick();
    tick(1'b1, 1'b0, 0, 0, 0, 1'b0, 0, 1'b0, 1'b0);
    check_eq("pc_after_rst", 32'(bus.pc), 32'd0);
    idle_tick();
    go(3);
    drain();

    phase = "random";
    for (int it = 0; it < 30; it++) begin
      for (int w = 0; w < int'($urandom_range(0, 4)); w++) begin
        load(int'($urandom_range(0, DEPTH - 1)), int'($urandom_range(0, 31)),
             int'($urandom_range(0, 4)));
      end
      go(int'($urandom_range(0, DEPTH + 1)));
      for (int c = 0; c < 400 && m_valid; c++) begin
        tick(1'b0, ($urandom % 8) == 0, int'($urandom_range(0, DEPTH - 1)),
             int'($urandom_range(0, 31)), int'($urandom_range(0, 4)),
             ($urandom % 8) == 0, int'($urandom_range(0, DEPTH + 1)),
             ($urandom % 4) == 0, ($urandom % 50) == 0);
      end
      drain();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
